countdown_timer: RTL



---
 rtl/countdown_timer.sv | 89 ++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Programmable down-counting timer qualified by clk_enable, with a one-cycle
// done pulse on expiry and optional auto-reload from the last loaded value.
module countdown_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] current_count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Priority is load > stop > start > tick; start only acts outside RUN and
    // tick only inside RUN, so those two never compete for the same cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = IDLE;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = HOLD;
            end
        end else if (state_q == IDLE || state_q == HOLD) begin
            if (start && count_q != ZERO) begin
                state_d = RUN;
            end
        end else if (state_q == RUN && clk_enable) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                done_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = EXPIRED;
                end
            end
        end
    end

    assign current_count = count_q;
    assign busy          = (state_q == RUN);
    assign expired       = (state_q == EXPIRED);
    assign done          = done_q;

endmodule
